// File: rtl/operand_sel_stage_pkg.sv
// Shared constants and helpers for the operand select stage.
package sel_stage_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_NSRC  = 4;
    localparam int ERR_CNT_W     = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    // Saturating increment used for the out-of-range error counter.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] count);
        return (count == ERR_CNT_MAX) ? count : count + 8'd1;
    endfunction

endpackage

// File: rtl/operand_sel_stage_if.sv
// Handshake bundle between the upstream producer, the select stage and the downstream consumer.
interface operand_sel_stage_if
    import sel_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NSRC  = DEFAULT_NSRC,
    parameter int SELW  = $clog2(NSRC)
);

    logic [NSRC*WIDTH-1:0] src;
    logic [SELW-1:0]       sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_sel;
    logic                  sel_err;
    logic [ERR_CNT_W-1:0]  err_count;

    modport master (
        output src, sel, in_valid, flush, out_ready,
        input  in_ready, out_valid, out_data, out_sel, sel_err, err_count
    );

    modport slave (
        input  src, sel, in_valid, flush, out_ready,
        output in_ready, out_valid, out_data, out_sel, sel_err, err_count
    );

endinterface

// File: rtl/operand_sel_stage_sel_mux_n.sv
// Combinational N-way source selector; flags indices with no matching source.
module sel_mux_n
    import sel_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NSRC  = DEFAULT_NSRC,
    parameter int SELW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [SELW-1:0]       sel,
    output logic [WIDTH-1:0]      data,
    output logic                  out_of_range
);

    // Scan every source; an index that matches none yields zero data and the range flag.
    always_comb begin
        data         = '0;
        out_of_range = 1'b1;
        for (int k = 0; k < NSRC; k++) begin
            if (sel == SELW'(k)) begin
                data         = src[k*WIDTH +: WIDTH];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_sel_stage.sv
// Operand select stage: picks one source per accepted sel and buffers it in a
// main/skid pair so in_ready can be a plain register while still streaming at
// one transfer per cycle.
module operand_sel_stage
    import sel_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NSRC  = DEFAULT_NSRC,
    parameter int SELW  = $clog2(NSRC)
) (
    input logic                clk,
    input logic                rst,
    operand_sel_stage_if.slave stage
);

    logic                 main_valid, main_valid_n;
    logic [WIDTH-1:0]     main_data, main_data_n;
    logic [SELW-1:0]      main_sel, main_sel_n;
    logic                 skid_valid, skid_valid_n;
    logic [WIDTH-1:0]     skid_data, skid_data_n;
    logic [SELW-1:0]      skid_sel, skid_sel_n;
    logic                 ready_q;
    logic                 sel_err_q, sel_err_n;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_n;

    logic [WIDTH-1:0]     mux_data;
    logic                 mux_oor;
    logic                 in_xfer;
    logic                 out_xfer;

    sel_mux_n #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SELW  (SELW)
    ) u_mux (
        .src          (stage.src),
        .sel          (stage.sel),
        .data         (mux_data),
        .out_of_range (mux_oor)
    );

    assign in_xfer  = stage.in_valid && ready_q;
    assign out_xfer = main_valid && stage.out_ready;

    // Next-state of the two entries: skid drains first, flush wins over everything.
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        main_sel_n   = main_sel;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_sel_n   = skid_sel;
        if (stage.flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid || out_xfer) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                main_sel_n   = skid_sel;
                skid_valid_n = 1'b0;
            end else if (in_xfer) begin
                main_valid_n = 1'b1;
                main_data_n  = mux_data;
                main_sel_n   = stage.sel;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_n = 1'b1;
            skid_data_n  = mux_data;
            skid_sel_n   = stage.sel;
        end
    end

    // Error bookkeeping counts every accepted out-of-range sel, including during a flush.
    always_comb begin
        sel_err_n   = sel_err_q;
        err_count_n = err_count_q;
        if (in_xfer && mux_oor) begin
            sel_err_n   = 1'b1;
            err_count_n = sat_inc(err_count_q);
        end
    end

    // State registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid  <= 1'b0;
            main_data   <= '0;
            main_sel    <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_sel    <= '0;
            ready_q     <= 1'b1;
            sel_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            main_valid  <= main_valid_n;
            main_data   <= main_data_n;
            main_sel    <= main_sel_n;
            skid_valid  <= skid_valid_n;
            skid_data   <= skid_data_n;
            skid_sel    <= skid_sel_n;
            ready_q     <= !skid_valid_n;
            sel_err_q   <= sel_err_n;
            err_count_q <= err_count_n;
        end
    end

    assign stage.in_ready  = ready_q;
    assign stage.out_valid = main_valid;
    assign stage.out_data  = main_data;
    assign stage.out_sel   = main_sel;
    assign stage.sel_err   = sel_err_q;
    assign stage.err_count = err_count_q;

endmodule
